// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: op and FSM encodings
// plus the per-operation context latched at launch.
package muldiv_hilo_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    typedef struct packed {
        logic              is_div;
        logic              neg_res;   // product or quotient must be negated
        logic              neg_rem;   // remainder must be negated
        logic              dbz;
        logic [DATA_W-1:0] rs_raw;    // original dividend, reported on divide by zero
    } op_ctx_t;

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Request/result bundle between the control unit and the HI/LO multiply/divide unit.
interface muldiv_hilo_unit_if;
    import muldiv_hilo_unit_pkg::*;

    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              mthi;
    logic              mtlo;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi_out, lo_out
    );

endinterface

// File: rtl/muldiv_iter_datapath.sv
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on
// unsigned magnitudes. acc = {upper, lower}: product, or {remainder, quotient}.
module muldiv_iter_datapath
    import muldiv_hilo_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [DATA_W-1:0]     mag_a,
    input  logic [DATA_W-1:0]     mag_b,
    output logic [2*DATA_W-1:0]   acc
);

    logic [DATA_W-1:0]   opnd;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     rem_sh;
    logic                rem_ge;
    logic [DATA_W-1:0]   rem_sub;

    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? opnd : '0)};
        rem_sh   = acc[2*DATA_W-1:DATA_W-1];
        rem_ge   = rem_sh >= {1'b0, opnd};
        // The difference is below the divisor, so it always fits in DATA_W bits.
        rem_sub  = rem_sh[DATA_W-1:0] - opnd;
        acc_next = {mul_sum, acc[DATA_W-1:1]};
        if (is_div) begin
            acc_next = rem_ge ? {rem_sub, acc[DATA_W-2:0], 1'b1}
                              : {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{DATA_W{1'b0}}, mag_a};
            opnd <= mag_b;
        end else if (step) begin
            acc  <= acc_next;
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: FSM, sign handling,
// HI/LO registers and MTHI/MTLO moves around the iterative datapath.
module muldiv_hilo_unit
    import muldiv_hilo_unit_pkg::*;
#(
    parameter int CYCLES = 32
) (
    input logic               clk,
    input logic               reset,
    muldiv_hilo_unit_if.slave bus
);

    localparam int CNT_W = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x,
                                                    input logic is_signed);
        return (is_signed && x < 0) ? -x : x;
    endfunction

    function automatic logic [DATA_W-1:0] neg_if32(input logic [DATA_W-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_if64(input logic [2*DATA_W-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    op_ctx_t             ctx;
    op_ctx_t             ctx_next;
    logic                busy_r;
    logic                done_r;
    logic                dbz_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic                launch;
    logic                is_signed;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [2*DATA_W-1:0] dp_acc;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;

    // FIX also accepts a start so operations can run back to back.
    assign launch    = bus.start && (state == ST_IDLE || state == ST_FIX);
    assign is_signed = ~bus.op[0];

    always_comb begin
        mag_a            = magnitude(bus.rs_data, is_signed);
        mag_b            = magnitude(bus.rt_data, is_signed);
        ctx_next.is_div  = bus.op[1];
        ctx_next.neg_res = is_signed & (bus.rs_data[DATA_W-1] ^ bus.rt_data[DATA_W-1]);
        ctx_next.neg_rem = is_signed & bus.rs_data[DATA_W-1];
        ctx_next.dbz     = bus.op[1] & (bus.rt_data == '0);
        ctx_next.rs_raw  = bus.rs_data;
    end

    muldiv_iter_datapath u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (launch),
        .step   (state == ST_RUN),
        .is_div (ctx.is_div),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .acc    (dp_acc)
    );

    always_comb begin
        prod   = neg_if64(dp_acc, ctx.neg_res);
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (ctx.is_div) begin
            if (ctx.dbz) begin
                res_hi = ctx.rs_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_if32(dp_acc[2*DATA_W-1:DATA_W], ctx.neg_rem);
                res_lo = neg_if32(dp_acc[DATA_W-1:0], ctx.neg_res);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ctx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_RUN;
                        cnt    <= '0;
                        ctx    <= ctx_next;
                        busy_r <= 1'b1;
                    end else begin
                        if (bus.mthi) hi_r <= bus.wdata;
                        if (bus.mtlo) lo_r <= bus.wdata;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi_r   <= res_hi;
                    lo_r   <= res_lo;
                    done_r <= 1'b1;
                    dbz_r  <= ctx.dbz;
                    if (bus.start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        ctx   <= ctx_next;
                    end else begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi_out      = hi_r;
    assign bus.lo_out      = lo_r;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: hand-computed HI/LO results, timing and
// ignored-input cases.
module tb_muldiv_hilo_unit;
    import muldiv_hilo_unit_pkg::*;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    muldiv_hilo_unit_if bus();

    muldiv_hilo_unit #(.CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output bit got);
        @(negedge clk);
        bus.op = o; bus.rs_data = a; bus.rt_data = b; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        nbusy = 0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) nbusy++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", bus.done); end
        nvec++; if (bus.div_by_zero !== 1'b0) begin nerr++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
        nvec++; if (bus.hi_out !== 32'h0) begin nerr++; $display("FAIL reset_hi: got %h want 0", bus.hi_out); end
        nvec++; if (bus.lo_out !== 32'h0) begin nerr++; $display("FAIL reset_lo: got %h want 0", bus.lo_out); end
    endtask

    task automatic test_multu();
        int nb; bit got;
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, got);
        nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL multu_done: got %b want 1", got); end
        nvec++; if (nb !== 33) begin nerr++; $display("FAIL multu_busy_cycles: got %0d want 33", nb); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL multu_busy_end: got %b want 0", bus.busy); end
        nvec++; if (bus.hi_out !== 32'hFFFFFFFE) begin nerr++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi_out); end
        nvec++; if (bus.lo_out !== 32'h00000001) begin nerr++; $display("FAIL multu_lo: got %h want 00000001", bus.lo_out); end
        @(negedge clk);
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL multu_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_signed();
        int nb; bit got;
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, nb, got);
        nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL mult_done: got %b want 1", got); end
        nvec++; if (bus.hi_out !== 32'hFFFFFFFF) begin nerr++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi_out); end
        nvec++; if (bus.lo_out !== 32'hFFFFFFF1) begin nerr++; $display("FAIL mult_lo: got %h want fffffff1", bus.lo_out); end
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, nb, got);
        nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL div_done: got %b want 1", got); end
        nvec++; if (bus.lo_out !== 32'hFFFFFFFD) begin nerr++; $display("FAIL div_lo: got %h want fffffffd", bus.lo_out); end
        nvec++; if (bus.hi_out !== 32'hFFFFFFFF) begin nerr++; $display("FAIL div_hi: got %h want ffffffff", bus.hi_out); end
        nvec++; if (bus.div_by_zero !== 1'b0) begin nerr++; $display("FAIL div_dbz: got %b want 0", bus.div_by_zero); end
    endtask

    task automatic test_div_corner();
        int nb; bit got;
        run_op(OP_DIVU, 32'd7, 32'd0, nb, got);
        nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL dbz_done: got %b want 1", got); end
        nvec++; if (bus.div_by_zero !== 1'b1) begin nerr++; $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero); end
        nvec++; if (bus.lo_out !== 32'hFFFFFFFF) begin nerr++; $display("FAIL dbz_lo: got %h want ffffffff", bus.lo_out); end
        nvec++; if (bus.hi_out !== 32'h00000007) begin nerr++; $display("FAIL dbz_hi: got %h want 00000007", bus.hi_out); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nb, got);
        nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL ovf_done: got %b want 1", got); end
        nvec++; if (bus.div_by_zero !== 1'b0) begin nerr++; $display("FAIL ovf_flag: got %b want 0", bus.div_by_zero); end
        nvec++; if (bus.lo_out !== 32'h80000000) begin nerr++; $display("FAIL ovf_lo: got %h want 80000000", bus.lo_out); end
        nvec++; if (bus.hi_out !== 32'h00000000) begin nerr++; $display("FAIL ovf_hi: got %h want 00000000", bus.hi_out); end
    endtask

    task automatic test_move();
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1 bus.mthi = 1'b0; bus.mtlo = 1'b0;
        @(negedge clk);
        nvec++; if (bus.hi_out !== 32'hA5A5A5A5) begin nerr++; $display("FAIL move_hi: got %h want a5a5a5a5", bus.hi_out); end
        nvec++; if (bus.lo_out !== 32'hA5A5A5A5) begin nerr++; $display("FAIL move_lo: got %h want a5a5a5a5", bus.lo_out); end
    endtask

    task automatic test_ignored();
        bit got;
        @(negedge clk);
        bus.op = OP_MULTU; bus.rs_data = 32'd6; bus.rt_data = 32'd7; bus.start = 1'b1;
        bus.mthi = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.mthi = 1'b0;
        @(negedge clk);
        nvec++; if (bus.hi_out !== 32'hA5A5A5A5) begin nerr++; $display("FAIL start_over_move: got %h want a5a5a5a5", bus.hi_out); end
        nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL ign_busy: got %b want 1", bus.busy); end
        repeat (3) @(negedge clk);
        bus.op = OP_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd3; bus.start = 1'b1;
        bus.mthi = 1'b1; bus.wdata = 32'h1234;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0;
        nvec++; if (bus.hi_out !== 32'hA5A5A5A5) begin nerr++; $display("FAIL mthi_busy: got %h want a5a5a5a5", bus.hi_out); end
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL ign_done: got %b want 1", got); end
        nvec++; if (bus.hi_out !== 32'h0) begin nerr++; $display("FAIL ign_hi: got %h want 00000000", bus.hi_out); end
        nvec++; if (bus.lo_out !== 32'd42) begin nerr++; $display("FAIL ign_lo: got %h want 0000002a", bus.lo_out); end
        @(negedge clk);
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL ign_no_restart: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        bus.op = OP_MULT; bus.rs_data = 32'd9; bus.rt_data = 32'd9; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        nvec++; if (bus.hi_out !== 32'h0) begin nerr++; $display("FAIL rst_mid_hi: got %h want 0", bus.hi_out); end
        nvec++; if (bus.lo_out !== 32'h0) begin nerr++; $display("FAIL rst_mid_lo: got %h want 0", bus.lo_out); end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        nvec++; if (saw_done !== 1'b0) begin nerr++; $display("FAIL rst_mid_no_done: got %b want 0", saw_done); end
    endtask

    task automatic test_back_to_back();
        int n; bit got;
        @(negedge clk);
        bus.op = OP_MULTU; bus.rs_data = 32'd3; bus.rt_data = 32'd4; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (32) @(negedge clk);
        @(negedge clk);
        nvec++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin nerr++; $display("FAIL b2b_fix: got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done); end
        bus.op = OP_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        nvec++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin nerr++; $display("FAIL b2b_overlap: got done=%b busy=%b want 1 1", bus.done, bus.busy); end
        nvec++; if (bus.lo_out !== 32'd12) begin nerr++; $display("FAIL b2b_first_lo: got %h want 0000000c", bus.lo_out); end
        nvec++; if (bus.hi_out !== 32'd0) begin nerr++; $display("FAIL b2b_first_hi: got %h want 00000000", bus.hi_out); end
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL b2b_done: got %b want 1", got); end
        nvec++; if (n !== 33) begin nerr++; $display("FAIL b2b_latency: got %0d want 33", n); end
        nvec++; if (bus.lo_out !== 32'd14) begin nerr++; $display("FAIL b2b_second_lo: got %h want 0000000e", bus.lo_out); end
        nvec++; if (bus.hi_out !== 32'd2) begin nerr++; $display("FAIL b2b_second_hi: got %h want 00000002", bus.hi_out); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL b2b_busy_end: got %b want 0", bus.busy); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_multu();
        test_signed();
        test_div_corner();
        test_move();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
